// File: rtl/audio_onchip_mem_arbiter.sv
// Round-robin arbiter sharing one single-port on-chip memory among NUM_REQ Avalon-MM requesters.
// Optional build macro AUDIO_MEM_ARB_PRIORITY_EN gives requester 0 fixed highest priority.
module audio_onchip_mem_arbiter #(
    parameter int NUM_REQ   = 3,
    parameter int ADDR_W    = 16,
    parameter int DATA_W    = 32,
    parameter int MAX_BURST = 8
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NUM_REQ-1:0]          req_read,
    input  logic [NUM_REQ-1:0]          req_write,
    input  logic [NUM_REQ*ADDR_W-1:0]   req_address,
    input  logic [NUM_REQ*DATA_W/8-1:0] req_byteenable,
    input  logic [NUM_REQ*DATA_W-1:0]   req_writedata,
    output logic [NUM_REQ-1:0]          req_waitrequest,
    output logic [DATA_W-1:0]           req_readdata,
    output logic [NUM_REQ-1:0]          req_readdatavalid,
    output logic [ADDR_W-1:0]           mem_address,
    output logic [DATA_W/8-1:0]         mem_byteenable,
    output logic                        mem_chipselect,
    output logic                        mem_write,
    output logic [DATA_W-1:0]           mem_writedata,
    output logic                        mem_clken,
    input  logic [DATA_W-1:0]           mem_readdata,
    output logic [NUM_REQ-1:0]          grant
);

    localparam int BE_W  = DATA_W / 8;
    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [IDX_W-1:0]   LAST_IDX   = IDX_W'(NUM_REQ - 1);
    localparam logic [IDX_W-1:0]   ONE_IDX    = IDX_W'(1);
    localparam logic [IDX_W:0]     NREQ_W     = (IDX_W + 1)'(NUM_REQ);
    localparam logic [7:0]         BURST_LAST = 8'(MAX_BURST - 1);
    localparam logic [NUM_REQ-1:0] ONE_HOT0   = {{(NUM_REQ - 1){1'b0}}, 1'b1};

    typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_OWN = 1'b1} state_t;

    state_t             r_state, w_state_nxt;
    logic [IDX_W-1:0]   r_owner, w_owner_nxt;
    logic [IDX_W-1:0]   r_rr_ptr, w_rr_nxt, w_rr_adv;
    logic [NUM_REQ-1:0] r_grant, w_grant_nxt;
    logic [7:0]         r_burst_cnt, w_burst_nxt;
    logic               r_rd_pending;
    logic [IDX_W-1:0]   r_rd_owner;
    logic               r_last_wr_vld;
    logic [ADDR_W-1:0]  r_last_wr_addr;

    logic [ADDR_W-1:0]  w_addr  [NUM_REQ];
    logic [BE_W-1:0]    w_be    [NUM_REQ];
    logic [DATA_W-1:0]  w_wdata [NUM_REQ];
    logic [NUM_REQ-1:0] w_req_any;
    logic               w_own, w_owner_rd, w_owner_wr, w_owner_req;
    logic               w_bubble, w_issue, w_burst_last, w_preempt, w_leave;
    logic               w_found, w_hit;
    logic [IDX_W-1:0]   w_pick, w_scan_idx;
    logic [IDX_W:0]     w_scan_raw;

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign w_addr[g]  = req_address[g*ADDR_W +: ADDR_W];
        assign w_be[g]    = req_byteenable[g*BE_W +: BE_W];
        assign w_wdata[g] = req_writedata[g*DATA_W +: DATA_W];
    end

    assign w_req_any    = req_read | req_write;
    assign w_own        = (r_state == ST_OWN) && !reset;
    assign w_owner_rd   = req_read[r_owner];
    assign w_owner_wr   = req_write[r_owner];
    assign w_owner_req  = w_owner_rd | w_owner_wr;
    // Memory is read-during-write don't-care: hold a read that hits the write issued just before.
    assign w_bubble     = w_own && r_last_wr_vld && w_owner_rd && !w_owner_wr &&
                          (w_addr[r_owner] == r_last_wr_addr);
    assign w_issue      = w_own && w_owner_req && !w_bubble;
    assign w_burst_last = (r_burst_cnt == BURST_LAST);
`ifdef AUDIO_MEM_ARB_PRIORITY_EN
    assign w_preempt    = (r_owner != {IDX_W{1'b0}}) && w_req_any[0];
`else
    assign w_preempt    = 1'b0;
`endif
    assign w_leave      = (w_issue && w_burst_last) || !w_owner_req || w_preempt;

    // Round-robin pick: first active requester at or after r_rr_ptr.
    always_comb begin
        w_found    = 1'b0;
        w_hit      = 1'b0;
        w_pick     = r_rr_ptr;
        w_scan_raw = {(IDX_W + 1){1'b0}};
        w_scan_idx = r_rr_ptr;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_scan_raw = {1'b0, r_rr_ptr} + (IDX_W + 1)'(k);
            w_scan_raw = (w_scan_raw >= NREQ_W) ? (w_scan_raw - NREQ_W) : w_scan_raw;
            w_scan_idx = w_scan_raw[IDX_W-1:0];
            w_hit      = !w_found && w_req_any[w_scan_idx];
            w_pick     = w_hit ? w_scan_idx : w_pick;
            w_found    = w_found | w_hit;
        end
`ifdef AUDIO_MEM_ARB_PRIORITY_EN
        w_pick  = w_req_any[0] ? {IDX_W{1'b0}} : w_pick;
        w_found = w_found | w_req_any[0];
`endif
    end

    // Pointer position after the current owner releases.
    always_comb begin
`ifdef AUDIO_MEM_ARB_PRIORITY_EN
        if (r_owner == {IDX_W{1'b0}}) begin
            w_rr_adv = r_rr_ptr;
        end else if (r_owner == LAST_IDX) begin
            w_rr_adv = ONE_IDX;
        end else begin
            w_rr_adv = r_owner + ONE_IDX;
        end
`else
        if (r_owner == LAST_IDX) begin
            w_rr_adv = {IDX_W{1'b0}};
        end else begin
            w_rr_adv = r_owner + ONE_IDX;
        end
`endif
    end

    // Next-state logic of the IDLE/OWN ownership FSM.
    always_comb begin
        w_state_nxt = r_state;
        w_owner_nxt = r_owner;
        w_rr_nxt    = r_rr_ptr;
        w_grant_nxt = r_grant;
        w_burst_nxt = r_burst_cnt;
        case (r_state)
            ST_IDLE: begin
                if (w_found) begin
                    w_state_nxt = ST_OWN;
                    w_owner_nxt = w_pick;
                    w_grant_nxt = ONE_HOT0 << w_pick;
                    w_burst_nxt = 8'd0;
                end else begin
                    w_grant_nxt = {NUM_REQ{1'b0}};
                end
            end
            ST_OWN: begin
                if (w_leave) begin
                    w_state_nxt = ST_IDLE;
                    w_grant_nxt = {NUM_REQ{1'b0}};
                    w_rr_nxt    = w_rr_adv;
                    w_burst_nxt = 8'd0;
                end else if (w_issue) begin
                    w_burst_nxt = r_burst_cnt + 8'd1;
                end else begin
                    w_burst_nxt = r_burst_cnt;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_grant_nxt = {NUM_REQ{1'b0}};
                w_burst_nxt = 8'd0;
            end
        endcase
    end

    // State, read-return pipeline and last-write tracking registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state        <= ST_IDLE;
            r_owner        <= {IDX_W{1'b0}};
            r_rr_ptr       <= {IDX_W{1'b0}};
            r_grant        <= {NUM_REQ{1'b0}};
            r_burst_cnt    <= 8'd0;
            r_rd_pending   <= 1'b0;
            r_rd_owner     <= {IDX_W{1'b0}};
            r_last_wr_vld  <= 1'b0;
            r_last_wr_addr <= {ADDR_W{1'b0}};
        end else begin
            r_state        <= w_state_nxt;
            r_owner        <= w_owner_nxt;
            r_rr_ptr       <= w_rr_nxt;
            r_grant        <= w_grant_nxt;
            r_burst_cnt    <= w_burst_nxt;
            r_rd_pending   <= w_issue && w_owner_rd && !w_owner_wr;
            r_rd_owner     <= r_owner;
            r_last_wr_vld  <= w_issue && w_owner_wr;
            r_last_wr_addr <= w_addr[r_owner];
        end
    end

    // Memory command and requester handshake outputs.
    always_comb begin
        req_waitrequest = {NUM_REQ{1'b1}};
        mem_address     = {ADDR_W{1'b0}};
        mem_byteenable  = {BE_W{1'b0}};
        mem_chipselect  = 1'b0;
        mem_write       = 1'b0;
        mem_writedata   = {DATA_W{1'b0}};
        if (w_own) begin
            req_waitrequest[r_owner] = w_bubble;
        end else begin
            req_waitrequest = {NUM_REQ{1'b1}};
        end
        if (w_issue) begin
            mem_address    = w_addr[r_owner];
            mem_byteenable = w_be[r_owner];
            mem_chipselect = 1'b1;
            mem_write      = w_owner_wr;
            mem_writedata  = w_owner_wr ? w_wdata[r_owner] : {DATA_W{1'b0}};
        end else begin
            mem_chipselect = 1'b0;
        end
    end

    assign req_readdatavalid = (r_rd_pending && !reset) ? (ONE_HOT0 << r_rd_owner)
                                                        : {NUM_REQ{1'b0}};
    assign req_readdata      = mem_readdata;
    assign mem_clken         = !reset;
    assign grant             = r_grant;

endmodule
